// File: rtl/rv_decode_queue.sv
// rv_decode_queue: RV instruction decoder feeding a QDEPTH-entry bundle FIFO.
// Decodes each accepted word into a control bundle, raises Int/IntData on
// illegal/ECALL/EBREAK and holds intake off until IntAck.
// Optional feature macro: RV_DEC_MULDIV_EN (OP funct7=0000001 decodes as a
// legal multi-cycle M-extension op; otherwise it is illegal).
module rv_decode_queue #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 2
) (
  input  logic            Clk_i,
  input  logic            Rst_i,
  input  logic            Flush_i,
  input  logic            InValid_i,
  output logic            InReady_o,
  input  logic [31:0]     DataInst_i,
  output logic            OutValid_o,
  input  logic            OutReady_i,
  output logic [4:0]      SelRS1_o,
  output logic [4:0]      SelRS2_o,
  output logic [4:0]      SelD_o,
  output logic [XLEN-1:0] DataIMM_o,
  output logic            RegDwe_o,
  output logic [6:0]      AluOp_o,
  output logic [15:0]     AluFunc_o,
  output logic [4:0]      MemOp_o,
  output logic [4:0]      CsrOp_o,
  output logic [11:0]     CsrAddr_o,
  output logic            TrapExit_o,
  output logic            MultiCy_o,
  output logic            Int_o,
  output logic [31:0]     IntData_o,
  input  logic            IntAck_i
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            dwe;
    logic [6:0]      aluop;
    logic [15:0]     alufunc;
    logic [4:0]      memop;
    logic [4:0]      csrop;
    logic [11:0]     csraddr;
    logic            trapexit;
    logic            multicy;
  } bundle_t;

  bundle_t          dec_b;
  logic [31:0]      dec_cause;
  logic             dec_illegal;
  bundle_t          mem_q [QDEPTH];
  logic [PW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             int_q, int_d;
  logic [31:0]      int_data_q, int_data_d;
  logic             push, pop;

  wire [6:0] opcode = DataInst_i[6:0];
  wire [2:0] f3     = DataInst_i[14:12];
  wire [6:0] f7     = DataInst_i[31:25];

  // Combinational decode of the incoming word into a bundle and trap cause.
  always_comb begin
    dec_b         = '0;
    dec_cause     = 32'd0;
    dec_illegal   = 1'b0;
    dec_b.rs1     = DataInst_i[19:15];
    dec_b.rs2     = DataInst_i[24:20];
    dec_b.rd      = DataInst_i[11:7];
    dec_b.aluop   = opcode;
    dec_b.alufunc = {6'b0, f7, f3};
    if (DataInst_i[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (opcode)
        7'b0110111, 7'b0010111: begin  // LUI / AUIPC
          dec_b.imm = XLEN'($signed({DataInst_i[31:12], 12'b0}));
          dec_b.dwe = 1'b1;
        end
        7'b1101111: begin              // JAL
          dec_b.imm = XLEN'($signed({DataInst_i[31], DataInst_i[19:12], DataInst_i[20],
                                     DataInst_i[30:21], 1'b0}));
          dec_b.dwe = (DataInst_i[11:7] != 5'd0);
        end
        7'b1100111: begin              // JALR
          dec_b.imm = XLEN'($signed(DataInst_i[31:20]));
          dec_b.dwe = (DataInst_i[11:7] != 5'd0);
        end
        7'b1100011: begin              // BRANCH
          dec_b.imm = XLEN'($signed({DataInst_i[31], DataInst_i[7], DataInst_i[30:25],
                                     DataInst_i[11:8], 1'b0}));
        end
        7'b0000011: begin              // LOAD
          dec_b.imm   = XLEN'($signed(DataInst_i[31:20]));
          dec_b.dwe   = 1'b1;
          dec_b.memop = {2'b10, f3};
        end
        7'b0100011: begin              // STORE
          dec_b.imm   = XLEN'($signed({DataInst_i[31:25], DataInst_i[11:7]}));
          dec_b.memop = {2'b11, f3};
        end
        7'b0010011: begin              // OP-IMM
          dec_b.imm = XLEN'($signed(DataInst_i[31:20]));
          dec_b.dwe = 1'b1;
        end
        7'b0110011: begin              // OP
          if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
            dec_b.dwe = 1'b1;
`ifdef RV_DEC_MULDIV_EN
          end else if (f7 == 7'b0000001) begin
            dec_b.dwe     = 1'b1;
            dec_b.multicy = 1'b1;
`endif
          end else begin
            dec_illegal = 1'b1;
          end
        end
        7'b0001111: dec_b.memop = 5'b01000;  // FENCE
        7'b1110011: begin              // SYSTEM
          if (f3 == 3'b000) begin
            case (DataInst_i[31:20])
              12'h000: dec_cause      = 32'd11;
              12'h001: dec_cause      = 32'd3;
              12'h302: dec_b.trapexit = 1'b1;
              default: dec_illegal    = 1'b1;
            endcase
          end else if (f3 == 3'b100) begin
            dec_illegal = 1'b1;
          end else begin
            // CSR access: the immediate is the zero-extended rs1/uimm field.
            dec_b.imm[4:0] = DataInst_i[19:15];
            dec_b.csrop    = {f3, ~(f3[1] & (DataInst_i[19:15] == 5'd0)),
                              (DataInst_i[11:7] != 5'd0)};
            dec_b.csraddr  = DataInst_i[31:20];
            dec_b.dwe      = (DataInst_i[11:7] != 5'd0);
          end
        end
        default: dec_illegal = 1'b1;
      endcase
    end
    // Illegal words still travel down the pipe, carrying the raw word as immediate.
    if (dec_illegal) begin
      dec_b.imm       = '0;
      dec_b.imm[31:0] = DataInst_i;
      dec_b.dwe       = 1'b0;
      dec_b.memop     = 5'd0;
      dec_b.csrop     = 5'd0;
      dec_b.csraddr   = 12'd0;
      dec_b.trapexit  = 1'b0;
      dec_b.multicy   = 1'b0;
      dec_cause       = 32'd2;
    end
  end

  assign InReady_o  = (count_q < CW'(QDEPTH)) & ~int_q & ~Flush_i;
  assign OutValid_o = (count_q != '0);
  assign push       = InValid_i & InReady_o;
  assign pop        = OutValid_o & OutReady_i;

  // Next-state for FIFO pointers/occupancy and the trap flag.
  always_comb begin
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    int_d      = int_q;
    int_data_d = int_data_q;
    if (Flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
    if (push && dec_cause != 32'd0) begin
      int_d      = 1'b1;
      int_data_d = dec_cause;
    end else if (IntAck_i && int_q) begin
      int_d = 1'b0;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      int_q      <= 1'b0;
      int_data_q <= 32'd0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      int_q      <= int_d;
      int_data_q <= int_data_d;
    end
  end

  // Bundle storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge Clk_i) begin
    if (push) mem_q[wptr_q] <= dec_b;
  end

  bundle_t head;
  assign head = OutValid_o ? mem_q[rptr_q] : '0;

  assign SelRS1_o   = head.rs1;
  assign SelRS2_o   = head.rs2;
  assign SelD_o     = head.rd;
  assign DataIMM_o  = head.imm;
  assign RegDwe_o   = head.dwe;
  assign AluOp_o    = head.aluop;
  assign AluFunc_o  = head.alufunc;
  assign MemOp_o    = head.memop;
  assign CsrOp_o    = head.csrop;
  assign CsrAddr_o  = head.csraddr;
  assign TrapExit_o = head.trapexit;
  assign MultiCy_o  = head.multicy;
  assign Int_o      = int_q;
  assign IntData_o  = int_data_q;

endmodule
